// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch front end placed directly upstream of the ICache
//   controller. It owns the PC, issues one word fetch per cycle on the bus_*
//   interface, and honours the controller's bus_streq stall. Returned words
//   are written into a small circular instruction buffer together with their
//   PCs. The decode stage pops that buffer with a valid/ready handshake. A
//   misaligned PC is not sent to the bus. Instead it produces an address-error
//   (AdEL) entry, and fetch then halts until the next redirect.
//
// Ports
//   aclk, areset       clock, synchronous active-high reset
//   redirect(_pc)      flush the buffer and restart fetch at redirect_pc
//   bus_en/addr        fetch request (addr is the current PC)
//   bus_wen/size       constant 0 / word
//   bus_cached         0 for kseg1 addresses (addr[31:29] == 3'b101)
//   bus_rdata          instruction word, valid the cycle after an accept
//   bus_streq          controller stall (miss/fill in progress)
//   bus_stall          fetch wanted to advance this cycle but could not
//   ib_valid/pc/inst/adel  head entry of the instruction buffer
//   ib_ready           decode consumes the head entry
//   ib_count           buffer occupancy
// ----------------------------------------------------------------------------
module if_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        bus_en,
   output logic [3:0]  bus_wen,
   output logic [31:0] bus_addr,
   output logic [2:0]  bus_size,
   output logic        bus_cached,
   input  logic [31:0] bus_rdata,
   input  logic        bus_streq,
   output logic        bus_stall,
   output logic        ib_valid,
   output logic [31:0] ib_pc,
   output logic [31:0] ib_inst,
   output logic        ib_adel,
   input  logic        ib_ready,
   output logic [2:0]  ib_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } state_e;

   // Fetch-side state
   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;

   // Instruction buffer
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   fifo_inst_q [DEPTH];
   logic          fifo_adel_q [DEPTH];

   // Per-cycle control
   logic [CW:0]   occupancy;
   logic          aligned;
   logic          issue_ok;
   logic          accept;
   logic          push;
   logic          pop;
   logic [31:0]   push_pc;
   logic [31:0]   push_inst;
   logic          push_adel;

   always_comb begin
      aligned = (pc_q[1:0] == 2'b00);

      // An outstanding response already owns a buffer slot, so it is counted
      // against the free space. A pop in this cycle does not free a slot until
      // the next cycle.
      occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      issue_ok  = !areset && (state_q == ST_RUN) && !redirect && (occupancy < DEPTH_W);

      accept = issue_ok && aligned && !bus_streq;
      pop    = (count_q != '0) && ib_ready;

      // A returning word and an AdEL entry never collide. The AdEL entry waits
      // for the outstanding response, so entries stay in program order.
      push_pc   = pc_q;
      push_inst = '0;
      push_adel = 1'b0;
      push      = 1'b0;
      if (inflight_q) begin
         push      = 1'b1;
         push_pc   = inflight_pc_q;
         push_inst = bus_rdata;
      end else if (issue_ok && !aligned) begin
         push      = 1'b1;
         push_adel = 1'b1;
      end

      state_d       = state_q;
      pc_d          = pc_q;
      inflight_d    = accept;
      inflight_pc_d = inflight_pc_q;
      if (accept) begin
         inflight_pc_d = pc_q;
         pc_d          = pc_q + 32'd4;
      end
      if (push_adel) begin
         state_d = ST_HALT;
      end

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else if (redirect) begin
         // Any outstanding response is dropped. The controller finishes its
         // fill on its own, and the next request uses the new PC.
         state_q       <= ST_RUN;
         pc_q          <= redirect_pc;
         inflight_q    <= 1'b0;
         inflight_pc_q <= inflight_pc_q;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Buffer storage has no reset. Entries are qualified by count_q.
   always_ff @(posedge aclk) begin
      if (!areset && !redirect && push) begin
         fifo_pc_q[wr_ptr_q]   <= push_pc;
         fifo_inst_q[wr_ptr_q] <= push_inst;
         fifo_adel_q[wr_ptr_q] <= push_adel;
      end
   end

   always_comb begin
      bus_en     = issue_ok && aligned;
      bus_wen    = '0;
      bus_addr   = pc_q;
      bus_size   = 3'b010;
      bus_cached = (pc_q[31:29] != 3'b101);
      bus_stall  = issue_ok ? bus_streq
                            : (!areset && (state_q == ST_RUN) && !redirect);
      ib_valid   = (count_q != '0);
      ib_pc      = fifo_pc_q[rd_ptr_q];
      ib_inst    = fifo_inst_q[rd_ptr_q];
      ib_adel    = fifo_adel_q[rd_ptr_q];
      ib_count   = 3'(count_q);
   end

endmodule
